// File: rtl/sram_ctrl_pkg.sv
// Shared types and codes for the AXI4 SRAM controller (axi_sram_ctrl).
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WRESP,
    S_RISSUE,
    S_RDATA
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Only full-width FIXED/INCR bursts may touch the SRAM.
  function automatic logic req_legal(input logic [1:0] burst, input logic [2:0] size,
                                     input logic [2:0] full_size);
    return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (size == full_size);
  endfunction

endpackage

// File: rtl/sram_ctrl_arb.sv
// AW/AR grant logic. `SRAM_CTRL_RR_ARB_EN selects round-robin; otherwise write has fixed priority.
module sram_ctrl_arb (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_w,
  input  logic req_r,
  output logic gnt_w,
  output logic gnt_r
);

  logic ptr;  // 0: write preferred, 1: read preferred

  always_comb begin
    gnt_w = en & req_w & (~req_r | ~ptr);
    gnt_r = en & req_r & (~req_w |  ptr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= 1'b0;
`ifdef SRAM_CTRL_RR_ARB_EN
    else if (gnt_w | gnt_r)
      ptr <= gnt_w;
`else
    else
      ptr <= 1'b0;
`endif
  end

endmodule

// File: rtl/axi_sram_ctrl.sv
// AXI4 slave sequencing a single-port byte-addressed SRAM, one burst in flight at a time.
// Arbitration policy set by `SRAM_CTRL_RR_ARB_EN (see sram_ctrl_arb).
module axi_sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int addr_wid = 26,
  parameter int data_wid = 32,
  parameter int id_wid   = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [id_wid-1:0]     awid,
  input  logic [addr_wid-1:0]   awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [data_wid-1:0]   wdata,
  input  logic [data_wid/8-1:0] wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [id_wid-1:0]     bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [id_wid-1:0]     arid,
  input  logic [addr_wid-1:0]   araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [id_wid-1:0]     rid,
  output logic [data_wid-1:0]   rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [data_wid-1:0]   mem_d,
  output logic [addr_wid-1:0]   mem_addr,
  output logic                  mem_wen,
  output logic [data_wid/8-1:0] mem_be,
  output logic                  mem_ceb,
  input  logic [data_wid-1:0]   mem_q
);

  localparam int         stroblen  = data_wid / 8;
  localparam logic [2:0] full_size = 3'($clog2(stroblen));

  state_t                state, next;
  logic [id_wid-1:0]     id;
  logic [addr_wid-1:0]   addr, addr_adv;
  logic [7:0]            cnt;
  logic [1:0]            burst;
  logic                  err;
  logic                  gnt_w, gnt_r;
  logic [1:0]            resp;

  sram_ctrl_arb u_arb (
    .clk   (aclk),
    .rst   (areset),
    .en    (state == S_IDLE),
    .req_w (awvalid),
    .req_r (arvalid),
    .gnt_w (gnt_w),
    .gnt_r (gnt_r)
  );

  // INCR wraps silently at the top of the address space.
  assign addr_adv = (burst == BURST_INCR) ? addr + addr_wid'(stroblen) : addr;

  always_comb begin
    next    = state;
    awready = 1'b0;
    arready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    mem_wen = 1'b0;
    mem_ceb = 1'b0;
    mem_be  = '0;
    mem_d   = '0;
    case (state)
      S_IDLE: begin
        awready = gnt_w;
        arready = gnt_r;
        if (gnt_w)      next = S_WDATA;
        else if (gnt_r) next = S_RISSUE;
      end
      S_WDATA: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_wen = ~err;
          mem_be  = err ? '0 : wstrb;
          mem_d   = err ? '0 : wdata;
          if (cnt == 8'd0) next = S_WRESP;
        end
      end
      S_WRESP: begin
        bvalid = 1'b1;
        if (bready) next = S_IDLE;
      end
      S_RISSUE: begin
        mem_ceb = ~err;
        next    = S_RDATA;
      end
      S_RDATA: begin
        rvalid = 1'b1;
        rlast  = (cnt == 8'd0);
        if (rready) next = (cnt == 8'd0) ? S_IDLE : S_RISSUE;
      end
      default: next = S_IDLE;
    endcase
  end

  assign resp     = err ? RESP_SLVERR : RESP_OKAY;
  assign bresp    = (state == S_WRESP) ? resp : RESP_OKAY;
  assign rresp    = (state == S_RDATA) ? resp : RESP_OKAY;
  assign bid      = id;
  assign rid      = id;
  assign rdata    = ((state == S_RDATA) && !err) ? mem_q : '0;
  assign mem_addr = addr;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= S_IDLE;
      id    <= '0;
      addr  <= '0;
      cnt   <= '0;
      burst <= BURST_FIXED;
      err   <= 1'b0;
    end else begin
      state <= next;
      if (gnt_w) begin
        id    <= awid;
        addr  <= awaddr;
        cnt   <= awlen;
        burst <= awburst;
        err   <= ~req_legal(awburst, awsize, full_size);
      end else if (gnt_r) begin
        id    <= arid;
        addr  <= araddr;
        cnt   <= arlen;
        burst <= arburst;
        err   <= ~req_legal(arburst, arsize, full_size);
      end
      if (state == S_WDATA && wvalid) begin
        // a misplaced wlast poisons the response but this beat is still written
        if (wlast != (cnt == 8'd0)) err <= 1'b1;
        if (cnt != 8'd0) begin
          cnt  <= cnt - 8'd1;
          addr <= addr_adv;
        end
      end
      if (state == S_RDATA && rready && cnt != 8'd0) begin
        cnt  <= cnt - 8'd1;
        addr <= addr_adv;
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_ctrl.sv
// Self-checking bench for axi_sram_ctrl: SRAM macro model plus byte-level reference memory.
module tb_axi_sram_ctrl;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  awid, arid, bid, rid;
  logic [25:0] awaddr, araddr, mem_addr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, arvalid, arready;
  logic [31:0] wdata, rdata, mem_d, mem_q;
  logic [3:0]  wstrb, mem_be;
  logic        wlast, wvalid, wready, bvalid, bready;
  logic        rlast, rvalid, rready, mem_wen, mem_ceb;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sram [4096] = '{default: 8'h00};
  logic [7:0] ref_mem [int];
  logic [31:0] wd[$];
  logic [3:0]  ws[$];

  always #5 aclk = ~aclk;

  axi_sram_ctrl dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .mem_d(mem_d), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_be(mem_be),
    .mem_ceb(mem_ceb), .mem_q(mem_q)
  );

  // SRAM macro: byte-enabled write, registered read data held until next strobe
  always @(posedge aclk) begin
    if (mem_wen)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) sram[int'(mem_addr[11:0]) + b] <= mem_d[8*b +: 8];
    if (mem_ceb)
      for (int b = 0; b < 4; b++)
        mem_q[8*b +: 8] <= sram[int'(mem_addr[11:0]) + b];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge aclk) if (!areset) chk("wen_ceb_excl", mem_wen & mem_ceb, 0);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic legal(input logic [1:0] burst, input logic [2:0] size);
    return (burst == 2'b00 || burst == 2'b01) && size == 3'd2;
  endfunction

  function automatic logic [25:0] beat_addr(input logic [25:0] a, input int i, input logic [1:0] burst);
    return (burst == 2'b01) ? 26'(a + 26'(4 * i)) : a;
  endfunction

  function automatic logic [31:0] ref_word(input logic [25:0] a);
    logic [31:0] w = '0;
    for (int b = 0; b < 4; b++)
      if (ref_mem.exists(int'(a) + b)) w[8*b +: 8] = ref_mem[int'(a) + b];
    return w;
  endfunction

  task automatic aw_set(input logic [3:0] id, input logic [25:0] a, input int len,
                        input logic [2:0] size, input logic [1:0] burst);
    awid = id; awaddr = a; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
  endtask

  task automatic ar_set(input logic [3:0] id, input logic [25:0] a, input int len,
                        input logic [2:0] size, input logic [1:0] burst);
    arid = id; araddr = a; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
  endtask

  task automatic wait_aw();
    int n = 0;
    #1;
    while (awready !== 1'b1 && n < 20) begin @(negedge aclk); #1; n++; end
    chk("aw_handshake", awready, 1);
    @(negedge aclk); awvalid = 1'b0;
  endtask

  task automatic wait_ar();
    int n = 0;
    #1;
    while (arready !== 1'b1 && n < 20) begin @(negedge aclk); #1; n++; end
    chk("ar_handshake", arready, 1);
    @(negedge aclk); arvalid = 1'b0;
  endtask

  // Entered on the negedge after the AW handshake; returns at the negedge after the B handshake.
  task automatic w_phase(input logic [3:0] id, input logic [25:0] a, input int len,
                         input logic [2:0] size, input logic [1:0] burst, input int bad_beat);
    logic        err = !legal(burst, size);
    logic [25:0] ba;
    logic [31:0] d;
    logic [3:0]  s;
    logic        lst;
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wvalid = 1'b0; #1;
        chk("w_gap_wen", mem_wen, 0);
        @(negedge aclk);
      end
      d   = (wd.size() > 0) ? wd.pop_front() : $urandom;
      s   = (ws.size() > 0) ? ws.pop_front() : 4'($urandom);
      ba  = beat_addr(a, i, burst);
      lst = (i == len) ^ (i == bad_beat);
      wdata = d; wstrb = s; wlast = lst; wvalid = 1'b1;
      #1;
      chk("wready", wready, 1);
      chk("mem_wen", mem_wen, !err);
      if (!err) begin
        chk("mem_addr_w", mem_addr, ba);
        chk("mem_be", mem_be, s);
        chk("mem_d", mem_d, d);
        for (int b = 0; b < 4; b++) if (s[b]) ref_mem[int'(ba) + b] = d[8*b +: 8];
      end
      if (lst != (i == len)) err = 1'b1;
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    #1;
    chk("bvalid", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, err ? 2'b10 : 2'b00);
    @(negedge aclk); bready = 1'b0;
  endtask

  // Entered on the negedge after the AR handshake; returns at the negedge after the last beat.
  task automatic r_phase(input logic [3:0] id, input logic [25:0] a, input int len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic        err = !legal(burst, size);
    logic [25:0] ba;
    for (int i = 0; i <= len; i++) begin
      ba = beat_addr(a, i, burst);
      #1;
      chk("rvalid_issue", rvalid, 0);
      chk("mem_ceb", mem_ceb, !err);
      if (!err) chk("mem_addr_r", mem_addr, ba);
      @(negedge aclk);
      if ($urandom_range(0, 3) == 0) begin
        #1; chk("rvalid_hold", rvalid, 1);
        @(negedge aclk);
      end
      rready = 1'b1;
      #1;
      chk("rvalid", rvalid, 1);
      chk("rdata", rdata, err ? 32'h0 : ref_word(ba));
      chk("rlast", rlast, i == len);
      chk("rresp", rresp, err ? 2'b10 : 2'b00);
      chk("rid", rid, id);
      @(negedge aclk); rready = 1'b0;
    end
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [25:0] a, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input int bad_beat);
    @(negedge aclk);
    aw_set(id, a, len, size, burst);
    wait_aw();
    w_phase(id, a, len, size, burst, bad_beat);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [25:0] a, input int len,
                          input logic [2:0] size, input logic [1:0] burst);
    @(negedge aclk);
    ar_set(id, a, len, size, burst);
    wait_ar();
    r_phase(id, a, len, size, burst);
  endtask

  logic [25:0] ra;
  int          rl, bad;
  logic [2:0]  rs;
  logic [1:0]  rb;

  initial begin
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    #3;
    chk("rst_awready", awready, 0); chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);   chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);   chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_ceb", mem_ceb, 0); chk("rst_mem_be", mem_be, 0);
    chk("rst_bresp", bresp, 0);     chk("rst_rresp", rresp, 0);
    chk("rst_bid", bid, 0);         chk("rst_rid", rid, 0);
    repeat (2) @(negedge aclk);
    areset = 1'b0;

    // INCR write of known pattern, then read it back
    wd = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    ws = '{4'hF, 4'hF, 4'hF, 4'hF};
    axi_write(4'h1, 26'h100, 3, 3'd2, 2'b01, -1);
    axi_read(4'h2, 26'h100, 3, 3'd2, 2'b01);

    // partial strobes over zeroed memory
    wd = '{32'hAABBCCDD}; ws = '{4'b0101};
    axi_write(4'h3, 26'h20, 0, 3'd2, 2'b01, -1);
    axi_read(4'h4, 26'h20, 0, 3'd2, 2'b01);
    chk("strb_merge_sram", {sram[16'h23], sram[16'h22], sram[16'h21], sram[16'h20]}, 32'h00BB00DD);

    // FIXED read holds address
    axi_write(4'h5, 26'h40, 0, 3'd2, 2'b00, -1);
    axi_read(4'h6, 26'h40, 2, 3'd2, 2'b00);

    // narrow write is rejected, SRAM untouched
    axi_write(4'h7, 26'h80, 0, 3'd1, 2'b01, -1);
    axi_read(4'h8, 26'h80, 0, 3'd2, 2'b01);

    // INCR wraps at the top of the address space
    axi_write(4'h9, 26'h3FFFFFC, 1, 3'd2, 2'b01, -1);
    axi_read(4'hA, 26'h3FFFFFC, 1, 3'd2, 2'b01);

    // misplaced wlast
    axi_write(4'hB, 26'h180, 3, 3'd2, 2'b01, 1);
    axi_read(4'hC, 26'h180, 3, 3'd2, 2'b01);

    // reset during beat 2 of a 4-beat write
    @(negedge aclk);
    aw_set(4'hD, 26'h200, 3, 3'd2, 2'b01);
    wait_aw();
    for (int i = 0; i < 2; i++) begin
      wdata = $urandom; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      #1;
      chk("rstb_mem_wen", mem_wen, 1);
      for (int b = 0; b < 4; b++) ref_mem[32'h200 + 4*i + b] = wdata[8*b +: 8];
      @(negedge aclk);
    end
    wdata = $urandom; wvalid = 1'b1; areset = 1'b1;
    #1;
    chk("rstb_wready", wready, 0);
    chk("rstb_bvalid", bvalid, 0);
    chk("rstb_mem_wen", mem_wen, 0);
    @(negedge aclk);
    areset = 1'b0; wvalid = 1'b0;

    // simultaneous AW/AR twice, arbiter pointer freshly reset to write
    @(negedge aclk);
    aw_set(4'h1, 26'h300, 0, 3'd2, 2'b01);
    ar_set(4'h2, 26'h200, 3, 3'd2, 2'b01);
    #1;
    chk("arb1_awready", awready, 1);
    chk("arb1_arready", arready, 0);
    @(negedge aclk); awvalid = 1'b0;
    w_phase(4'h1, 26'h300, 0, 3'd2, 2'b01, -1);
    aw_set(4'h3, 26'h304, 0, 3'd2, 2'b01);
    #1;
`ifdef SRAM_CTRL_RR_ARB_EN
    chk("arb2_awready", awready, 0);
    chk("arb2_arready", arready, 1);
    @(negedge aclk); arvalid = 1'b0;
    r_phase(4'h2, 26'h200, 3, 3'd2, 2'b01);
    wait_aw();
    w_phase(4'h3, 26'h304, 0, 3'd2, 2'b01, -1);
`else
    chk("arb2_awready", awready, 1);
    chk("arb2_arready", arready, 0);
    @(negedge aclk); awvalid = 1'b0;
    w_phase(4'h3, 26'h304, 0, 3'd2, 2'b01, -1);
    wait_ar();
    r_phase(4'h2, 26'h200, 3, 3'd2, 2'b01);
`endif
    axi_read(4'h4, 26'h300, 1, 3'd2, 2'b01);

    // randomized mix, including illegal bursts/sizes and bad wlast
    for (int t = 0; t < 40; t++) begin
      ra  = 26'($urandom_range(0, 240)) * 26'd4;
      rl  = $urandom_range(0, 7);
      rs  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
      rb  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, rl)) : -1;
      if ($urandom_range(0, 1) == 1) axi_write(4'($urandom), ra, rl, rs, rb, bad);
      else                           axi_read(4'($urandom), ra, rl, rs, rb);
    end

    repeat (2) @(negedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
